// File: rtl/morra_pkg.sv
// morra_pkg: shared types and default sizes for the MorraCinese scoreboard.
//   result_e   : round/match result code as produced by the game core.
//   sb_state_e : scoreboard control state.
//   DEF_*      : default parameter values used by the scoreboard and bench.
package morra_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    P1   = 2'b01,
    P2   = 2'b10,
    DRAW = 2'b11
  } result_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DONE = 2'b10
  } sb_state_e;

  localparam int DEF_HIST_DEPTH = 8;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_ROUND_W    = 4;

endpackage

// File: rtl/morra_scoreboard_if.sv
// morra_scoreboard_if: bundles the game-core inputs, tally outputs and the
// history drain port of the scoreboard.
//   master : game core / display side (drives inizia, manche, partita, hist_pop)
//   slave  : scoreboard (drives tallies, match_done, last_winner, hist_*)
interface morra_scoreboard_if
  import morra_pkg::*;
#(
  parameter int ROUND_W = DEF_ROUND_W,
  parameter int CNT_W   = DEF_CNT_W
);

  logic               inizia;
  logic [1:0]         manche;
  logic [1:0]         partita;
  logic [ROUND_W-1:0] rounds_played;
  logic [ROUND_W-1:0] p1_rounds;
  logic [ROUND_W-1:0] p2_rounds;
  logic [CNT_W-1:0]   p1_matches;
  logic [CNT_W-1:0]   p2_matches;
  logic [CNT_W-1:0]   draw_matches;
  logic               match_done;
  logic [1:0]         last_winner;
  logic               hist_valid;
  logic [1:0]         hist_data;
  logic               hist_pop;
  logic               hist_ovf;

  modport master (
    output inizia, manche, partita, hist_pop,
    input  rounds_played, p1_rounds, p2_rounds,
    input  p1_matches, p2_matches, draw_matches,
    input  match_done, last_winner, hist_valid, hist_data, hist_ovf
  );

  modport slave (
    input  inizia, manche, partita, hist_pop,
    output rounds_played, p1_rounds, p2_rounds,
    output p1_matches, p2_matches, draw_matches,
    output match_done, last_winner, hist_valid, hist_data, hist_ovf
  );

endinterface

// File: rtl/morra_hist_fifo.sv
// morra_hist_fifo: circular history of round codes with overwrite-on-full.
//   clk, rst_n : clock, synchronous active-low reset
//   push, push_data : store a round code (overwrites the oldest when full)
//   pop        : consume the oldest entry (ignored when empty)
//   flush      : empty the buffer and clear ovf (wins over push/pop)
//   valid      : buffer not empty
//   data       : oldest entry, show-ahead; 00 when empty
//   ovf        : sticky, an entry was overwritten since the last flush/reset
module morra_hist_fifo
  import morra_pkg::*;
#(
  parameter int DEPTH = DEF_HIST_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [1:0] push_data,
  input  logic       pop,
  input  logic       flush,
  output logic       valid,
  output logic [1:0] data,
  output logic       ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [AW:0]   count_q;
  logic          ovf_q;

  logic do_pop;
  logic full;

  // A pop on an empty buffer never happens, even when a push arrives in the
  // same cycle: the pushed code only becomes visible on the next cycle.
  always_comb begin
    full   = (count_q == FULL_CNT);
    do_pop = pop && (count_q != '0);
  end

  // Storage is pure data: it is never reset, validity comes from count_q.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[tail_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        tail_q <= tail_q + 1'b1;
      end
      if (push && !do_pop) begin
        if (full) begin
          // Overwrite: the oldest entry is dropped by advancing head.
          head_q <= head_q + 1'b1;
          ovf_q  <= 1'b1;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end else if (do_pop && !push) begin
        head_q  <= head_q + 1'b1;
        count_q <= count_q - 1'b1;
      end else if (do_pop && push) begin
        head_q <= head_q + 1'b1;
      end
    end
  end

  always_comb begin
    valid = (count_q != '0);
    data  = valid ? mem[head_q] : 2'b00;
    ovf   = ovf_q;
  end

endmodule

// File: rtl/morra_scoreboard.sv
// morra_scoreboard: per-match and cumulative tallies of the MorraCinese game.
//   clk, rst_n : clock, synchronous active-low reset
//   bus.slave  : inizia/manche/partita from the game core, hist_pop from the
//                display side; tallies, match_done, last_winner and the
//                history drain (hist_valid/hist_data/hist_ovf) back out.
// Round counters are ROUND_W wide, match tallies CNT_W wide; all saturate.
module morra_scoreboard
  import morra_pkg::*;
#(
  parameter int HIST_DEPTH = DEF_HIST_DEPTH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int ROUND_W    = DEF_ROUND_W
) (
  input  logic              clk,
  input  logic              rst_n,
  morra_scoreboard_if.slave bus
);

  sb_state_e state_q;
  sb_state_e state_d;

  logic round_ok;
  logic close;

  logic [ROUND_W-1:0] rounds_q;
  logic [ROUND_W-1:0] p1r_q;
  logic [ROUND_W-1:0] p2r_q;
  logic [CNT_W-1:0]   p1m_q;
  logic [CNT_W-1:0]   p2m_q;
  logic [CNT_W-1:0]   drm_q;
  logic               done_q;
  logic [1:0]         last_q;

  function automatic logic [ROUND_W-1:0] sat_round(input logic [ROUND_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // inizia dominates: any manche/partita seen alongside it is dropped.
  always_comb begin
    state_d  = state_q;
    round_ok = 1'b0;
    close    = 1'b0;
    if (bus.inizia) begin
      state_d = PLAY;
    end else if (state_q == PLAY) begin
      round_ok = (bus.manche != NONE);
      close    = (bus.partita != NONE);
      if (close) begin
        state_d = DONE;
      end
    end
  end

  // Round and match tallies, one edge after the qualifying input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rounds_q <= '0;
      p1r_q    <= '0;
      p2r_q    <= '0;
      p1m_q    <= '0;
      p2m_q    <= '0;
      drm_q    <= '0;
      done_q   <= 1'b0;
      last_q   <= 2'b00;
    end else begin
      done_q <= close;
      if (bus.inizia) begin
        rounds_q <= '0;
        p1r_q    <= '0;
        p2r_q    <= '0;
      end else begin
        if (round_ok) begin
          rounds_q <= sat_round(rounds_q);
          case (bus.manche)
            P1:      p1r_q <= sat_round(p1r_q);
            P2:      p2r_q <= sat_round(p2r_q);
            default: ;
          endcase
        end
        if (close) begin
          last_q <= bus.partita;
          case (bus.partita)
            P1:      p1m_q <= sat_cnt(p1m_q);
            P2:      p2m_q <= sat_cnt(p2m_q);
            DRAW:    drm_q <= sat_cnt(drm_q);
            default: ;
          endcase
        end
      end
    end
  end

  morra_hist_fifo #(
    .DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (round_ok),
    .push_data (bus.manche),
    .pop       (bus.hist_pop),
    .flush     (bus.inizia),
    .valid     (bus.hist_valid),
    .data      (bus.hist_data),
    .ovf       (bus.hist_ovf)
  );

  always_comb begin
    bus.rounds_played = rounds_q;
    bus.p1_rounds     = p1r_q;
    bus.p2_rounds     = p2r_q;
    bus.p1_matches    = p1m_q;
    bus.p2_matches    = p2m_q;
    bus.draw_matches  = drm_q;
    bus.match_done    = done_q;
    bus.last_winner   = last_q;
  end

endmodule
